// File: rtl/tt_sel_pkg.sv
// Shared definitions for the tt_sel_ctrl design-select block: sequencer state
// encoding, register offsets, CTRL/STATUS bit positions and a hold-time helper.
package tt_sel_pkg;

    // Sequencer phases. The block leaves reset in ST_POST so that the design
    // selected after power-up is held in reset for one hold time.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRE    = 2'd1,
        ST_SWITCH = 2'd2,
        ST_POST   = 2'd3
    } seq_state_e;

    // Byte offsets of the registers within the 16-byte window
    localparam logic [3:0] OFF_SEL    = 4'h0;
    localparam logic [3:0] OFF_CTRL   = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_TIMING = 4'hC;

    // CTRL bits
    localparam int CTRL_GO_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // STATUS bits
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_RANGE_BIT = 2;
    localparam int STAT_LOST_BIT  = 3;

    // A hold time of zero would make a phase vanish; treat it as one cycle.
    function automatic logic [7:0] eff_timing(input logic [7:0] t);
        return (t == 8'd0) ? 8'd1 : t;
    endfunction

endpackage

// File: rtl/tt_sel_seq.sv
// Design-switch sequencer: holds the design in reset for a hold time (PRE),
// swaps si_sel for one cycle (SWITCH), holds again (POST), then releases.
// The index to apply is latched when GO is taken, so SEL writes made while a
// sequence runs only affect the next GO. The first POST after reset is the
// boot hold and does not report completion.
module tt_sel_seq
    import tt_sel_pkg::*;
#(
    parameter int SEL_W       = 10,
    parameter int DEFAULT_SEL = 0,
    parameter int RST_CYC     = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             go,
    input  logic [SEL_W-1:0] sel,
    input  logic [7:0]       timing,
    output logic [SEL_W-1:0] si_sel,
    output logic             design_rst,
    output logic             busy,
    output logic             done_pulse
);

    localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(DEFAULT_SEL);
    localparam logic [7:0]       BOOT_CNT = eff_timing(8'(RST_CYC));

    seq_state_e       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0] si_sel_q, si_sel_d;
    logic [SEL_W-1:0] sel_lat_q, sel_lat_d;
    logic             boot_q, boot_d;
    logic             design_rst_q, design_rst_d;

    // State register; reset lands in the boot hold with the default index
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= ST_POST;
            cnt_q        <= BOOT_CNT;
            si_sel_q     <= DEF_SEL;
            sel_lat_q    <= DEF_SEL;
            boot_q       <= 1'b1;
            design_rst_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            si_sel_q     <= si_sel_d;
            sel_lat_q    <= sel_lat_d;
            boot_q       <= boot_d;
            design_rst_q <= design_rst_d;
        end
    end

    // Next-state logic: each hold phase loads the live TIMING on entry and
    // counts down to 1
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        si_sel_d   = si_sel_q;
        sel_lat_d  = sel_lat_q;
        boot_d     = boot_q;
        done_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d   = ST_PRE;
                    cnt_d     = eff_timing(timing);
                    sel_lat_d = sel;
                end
            end
            ST_PRE: begin
                if (cnt_q <= 8'd1) begin
                    state_d  = ST_SWITCH;
                    si_sel_d = sel_lat_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SWITCH: begin
                state_d = ST_POST;
                cnt_d   = eff_timing(timing);
            end
            ST_POST: begin
                if (cnt_q <= 8'd1) begin
                    state_d    = ST_IDLE;
                    boot_d     = 1'b0;
                    done_pulse = !boot_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        design_rst_d = (state_d != ST_IDLE);
    end

    assign si_sel     = si_sel_q;
    assign design_rst = design_rst_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: rtl/tt_sel_ctrl.sv
// Wishbone slave owning design selection for tt_top. Firmware writes SEL and
// pulses GO; the sequencer performs the reset-protected switch of si_sel.
// Optional feature macro: TT_SEL_IRQ_EN enables the CTRL.IRQ_EN bit and the
// level interrupt irq_o = DONE & IRQ_EN; without it irq_o is tied low.
module tt_sel_ctrl
    import tt_sel_pkg::*;
#(
    parameter int          SEL_W       = 10,
    parameter int          N_DESIGNS   = 32,
    parameter int          DEFAULT_SEL = 0,
    parameter int          RST_CYC     = 8,
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic [SEL_W-1:0] si_sel,
    output logic             design_rst_o,
    output logic             busy_o,
    output logic             irq_o
);

    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [7:0]       timing_q, timing_d;
    logic             done_q, done_d;
    logic             range_q, range_d;
    logic             lost_q, lost_d;
`ifdef TT_SEL_IRQ_EN
    logic             irq_en_q, irq_en_d;
`endif

    logic             req, acc, wr, rd;
    logic [3:0]       off;
    logic             go_req, in_range, seq_go;
    logic             seq_busy, seq_done;
    logic [31:0]      rdata;
    logic [SEL_W-1:0] sel_wmask;
    logic             unused_ok;

    // Bus decode: a new access is taken only while ack is low, which gives the
    // mandatory idle cycle after every ack
    assign req    = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign acc    = req && !ack_q;
    assign wr     = acc && wbs_we_i;
    assign rd     = acc && !wbs_we_i;
    assign off    = wbs_adr_i[3:0];

    assign go_req   = wr && (off == OFF_CTRL) && wbs_sel_i[0] && wbs_dat_i[CTRL_GO_BIT];
    assign in_range = (32'(sel_q) < 32'(N_DESIGNS));
    assign seq_go   = go_req && !seq_busy && in_range;

    // Per-bit write mask for SEL: only byte lanes 0 and 1 are writable
    for (genvar gi = 0; gi < SEL_W; gi++) begin : g_sel_mask
        if (gi < 16) begin : g_lane
            assign sel_wmask[gi] = wbs_sel_i[gi / 8];
        end else begin : g_nolane
            assign sel_wmask[gi] = 1'b0;
        end
    end

    // Lanes 2/3 and upper data bits carry nothing for this block
    assign unused_ok = &{1'b0, wbs_dat_i, wbs_sel_i};

    tt_sel_seq #(
        .SEL_W      (SEL_W),
        .DEFAULT_SEL(DEFAULT_SEL),
        .RST_CYC    (RST_CYC)
    ) u_seq (
        .clk        (wb_clk_i),
        .srst       (wb_rst_i),
        .go         (seq_go),
        .sel        (sel_q),
        .timing     (timing_q),
        .si_sel     (si_sel),
        .design_rst (design_rst_o),
        .busy       (seq_busy),
        .done_pulse (seq_done)
    );

    // Register file and bus response flops
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            sel_q    <= '0;
            timing_q <= 8'(RST_CYC);
            done_q   <= 1'b0;
            range_q  <= 1'b0;
            lost_q   <= 1'b0;
`ifdef TT_SEL_IRQ_EN
            irq_en_q <= 1'b0;
`endif
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            timing_q <= timing_d;
            done_q   <= done_d;
            range_q  <= range_d;
            lost_q   <= lost_d;
`ifdef TT_SEL_IRQ_EN
            irq_en_q <= irq_en_d;
`endif
        end
    end

    // Read mux; unmapped offsets and GO read as zero
    always_comb begin
        rdata = '0;
        case (off)
            OFF_SEL:    rdata[SEL_W-1:0] = sel_q;
`ifdef TT_SEL_IRQ_EN
            OFF_CTRL:   rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
`endif
            OFF_STATUS: begin
                rdata[STAT_BUSY_BIT]  = seq_busy;
                rdata[STAT_DONE_BIT]  = done_q;
                rdata[STAT_RANGE_BIT] = range_q;
                rdata[STAT_LOST_BIT]  = lost_q;
            end
            OFF_TIMING: rdata[7:0] = timing_q;
            default:    rdata = '0;
        endcase
    end

    // Register writes and sticky status: clears are applied before sets so a
    // same-cycle event wins over a W1C
    always_comb begin
        ack_d    = acc;
        dat_d    = rd ? rdata : '0;
        sel_d    = sel_q;
        timing_d = timing_q;
        done_d   = done_q;
        range_d  = range_q;
        lost_d   = lost_q;
`ifdef TT_SEL_IRQ_EN
        irq_en_d = irq_en_q;
`endif
        if (wr && (off == OFF_SEL)) begin
            sel_d = (sel_q & ~sel_wmask) | (wbs_dat_i[SEL_W-1:0] & sel_wmask);
        end
        if (wr && (off == OFF_TIMING) && wbs_sel_i[0]) begin
            timing_d = wbs_dat_i[7:0];
        end
`ifdef TT_SEL_IRQ_EN
        if (wr && (off == OFF_CTRL) && wbs_sel_i[0]) begin
            irq_en_d = wbs_dat_i[CTRL_IRQ_EN_BIT];
        end
`endif
        if (wr && (off == OFF_STATUS) && wbs_sel_i[0]) begin
            if (wbs_dat_i[STAT_DONE_BIT])  done_d  = 1'b0;
            if (wbs_dat_i[STAT_RANGE_BIT]) range_d = 1'b0;
            if (wbs_dat_i[STAT_LOST_BIT])  lost_d  = 1'b0;
        end
        if (seq_done)                           done_d  = 1'b1;
        if (go_req && !seq_busy && !in_range)   range_d = 1'b1;
        if (go_req && seq_busy)                 lost_d  = 1'b1;
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign busy_o    = seq_busy;
`ifdef TT_SEL_IRQ_EN
    assign irq_o = done_q && irq_en_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_tt_sel_ctrl.sv
// Directed bench for tt_sel_ctrl. Register reads and sequencer waveforms are
// predicted into queues when stimulus is issued and popped as the DUT answers.
// Timing reference: "k=0" is the cycle GO is acknowledged; busy/design_rst are
// high for k=0..2T, si_sel takes the new index at k=T, all idle at k=2T+1.
module tb_tt_sel_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_SEL = BASE + 32'h0;
    localparam logic [31:0] A_CTRL = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_TIM = BASE + 32'hC;
`ifdef TT_SEL_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  bsel = 4'hF;
    logic [31:0] wdat = '0, adr = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [9:0]  si_sel;
    logic        drst, busy, irq;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] trace_q[$];

    always #5 clk = ~clk;

    tt_sel_ctrl dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (bsel),
        .wbs_dat_i   (wdat),
        .wbs_adr_i   (adr),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .si_sel      (si_sel),
        .design_rst_o(drst),
        .busy_o      (busy),
        .irq_o       (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
        logic got;
        got = 1'b0;
        r = 'x;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; bsel = s;
        for (int i = 0; i < 4 && !got; i++) begin
            step();
            if (ack) begin
                got = 1'b1;
                r = rdat;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; bsel = 4'hF;
        check("ack_seen", {31'b0, got}, 32'd1);
        $display("[TB] %s adr=%h wdat=%h sel=%h rdat=%h", w ? "WR" : "RD", a, d, s, r);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        wb_xfer(1'b1, a, d, s, r);
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] expv, input string tag);
        logic [31:0] r;
        logic [31:0] e;
        exp_q.push_back(expv);
        wb_xfer(1'b0, a, 32'h0, 4'hF, r);
        e = exp_q.pop_front();
        check(tag, r, e);
    endtask

    // Predict the per-cycle {busy, design_rst, si_sel} trace of one sequence,
    // fire GO, then compare cycle by cycle from k=0
    task automatic go_and_trace(input int t, input logic [9:0] old_sel,
                                input logic [9:0] new_sel, input logic [31:0] ctrl);
        logic [31:0] e;
        logic        b;
        for (int k = 0; k <= 2 * t + 1; k++) begin
            b = (k <= 2 * t);
            trace_q.push_back({20'b0, b, b, (k < t) ? old_sel : new_sel});
        end
        wb_write(A_CTRL, ctrl, 4'hF);
        while (trace_q.size() > 0) begin
            e = trace_q.pop_front();
            check("seq_trace", {20'b0, busy, drst, si_sel}, e);
            if (trace_q.size() > 0) step();
        end
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && busy; i++) step();
        check("idle_reached", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int acks;
        logic [31:0] e;

        // Reset values
        repeat (3) step();
        check("rst_si_sel", {22'b0, si_sel}, 32'd0);
        check("rst_drst", {31'b0, drst}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);

        // Boot hold: 8 cycles of design reset after release, then idle
        rst = 1'b0;
        check("boot_c1", {30'b0, busy, drst}, 32'd3);
        for (int i = 0; i < 7; i++) begin
            step();
            check("boot_hold", {30'b0, busy, drst}, 32'd3);
        end
        step();
        check("boot_release", {30'b0, busy, drst}, 32'd0);
        check("boot_si_sel", {22'b0, si_sel}, 32'd0);
        wb_read(A_STAT, 32'h0, "boot_status");
        wb_read(A_TIM, 32'd8, "boot_timing");

        // SEL=5, TIMING=3 switch with IRQ_EN requested
        wb_write(A_TIM, 32'd3, 4'hF);
        wb_write(A_SEL, 32'd5, 4'hF);
        wb_read(A_SEL, 32'd5, "sel_rb");
        wb_write(A_CTRL, 32'h2, 4'hF);
        wb_read(A_CTRL, {30'b0, IRQ_ON, 1'b0}, "ctrl_rb");
        go_and_trace(3, 10'd0, 10'd5, 32'h3);
        check("irq_done", {31'b0, irq}, {31'b0, IRQ_ON});
        wb_read(A_STAT, 32'h2, "status_done");
        wb_write(A_STAT, 32'h2, 4'hF);
        wb_read(A_STAT, 32'h0, "status_done_clr");
        check("irq_clr", {31'b0, irq}, 32'd0);

        // Out-of-range index: no sequence, RANGE_ERR
        wb_write(A_SEL, 32'd40, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'hF);
        check("range_busy", {31'b0, busy}, 32'd0);
        step();
        step();
        check("range_drst", {31'b0, drst}, 32'd0);
        check("range_si_sel", {22'b0, si_sel}, 32'd5);
        wb_read(A_STAT, 32'h4, "status_range");

        // GO while busy is lost; SEL written mid-sequence waits for next GO
        wb_write(A_TIM, 32'd6, 4'hF);
        wb_write(A_SEL, 32'd9, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'hF);
        check("seq2_busy", {31'b0, busy}, 32'd1);
        wb_write(A_SEL, 32'd7, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'hF);
        check("seq2_pre_si_sel", {22'b0, si_sel}, 32'd5);
        wait_idle(40);
        check("seq2_si_sel", {22'b0, si_sel}, 32'd9);
        wb_read(A_STAT, 32'hE, "status_lost");
        wb_write(A_STAT, 32'hE, 4'hF);
        wb_read(A_STAT, 32'h0, "status_w1c_all");
        wb_write(A_CTRL, 32'h1, 4'hF);
        wait_idle(40);
        check("seq3_si_sel", {22'b0, si_sel}, 32'd7);
        wb_write(A_STAT, 32'h2, 4'hF);

        // Byte lanes: only lanes 0/1 write SEL
        wb_write(A_SEL, 32'h3FF, 4'h1);
        wb_read(A_SEL, 32'h0FF, "sel_lane0");
        wb_write(A_SEL, 32'h3FF, 4'h3);
        wb_read(A_SEL, 32'h3FF, "sel_lane01");

        // Reset during POST returns everything to reset values
        wb_write(A_SEL, 32'd3, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'hF);
        repeat (7) step();
        check("post_si_sel", {22'b0, si_sel}, 32'd3);
        rst = 1'b1;
        step();
        check("midrst_si_sel", {22'b0, si_sel}, 32'd0);
        check("midrst_drst", {31'b0, drst}, 32'd1);
        check("midrst_busy", {31'b0, busy}, 32'd1);
        check("midrst_ack", {31'b0, ack}, 32'd0);
        check("midrst_irq", {31'b0, irq}, 32'd0);
        step();
        rst = 1'b0;
        wb_read(A_STAT, 32'h1, "boot2_status_busy");
        wait_idle(20);
        wb_read(A_TIM, 32'd8, "rst_timing");

        // Back-to-back reads with strobe held, then an unmapped offset
        acks = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0;
        for (int a = 0; a < 4; a++) begin
            logic got;
            got = 1'b0;
            adr = BASE + 32'(a * 4);
            case (a)
                0: exp_q.push_back(32'h0);
                1: exp_q.push_back(32'h0);
                2: exp_q.push_back(32'h0);
                default: exp_q.push_back(32'd8);
            endcase
            for (int i = 0; i < 4 && !got; i++) begin
                step();
                if (ack) begin
                    got = 1'b1;
                    acks++;
                    e = exp_q.pop_front();
                    check("b2b_rd", rdat, e);
                    $display("[TB] RD adr=%h rdat=%h (burst)", adr, rdat);
                end
            end
            if (!got) void'(exp_q.pop_front());
        end
        stb = 1'b0; cyc = 1'b0;
        step();
        check("b2b_ack_low", {31'b0, ack}, 32'd0);
        check("b2b_ack_count", 32'(acks), 32'd4);
        acks = 0;
        cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h10;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ack) acks++;
        end
        stb = 1'b0; cyc = 1'b0;
        $display("[TB] RD adr=%h unmapped, acks=%0d", BASE + 32'h10, acks);
        check("unmapped_no_ack", 32'(acks), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
